sram_pattern_writer: RTL and testbench

//  Write-then-verify initiator for the sram_driver module interface (ready/re/start/address/data_in/data_out).

---
 rtl/sram_pattern_writer.sv | 179 +++++++++++++++++
 tb/tb_sram_pattern_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_writer.sv
// sram_pattern_writer
//   Write-then-verify initiator for the sram_driver ready/re/start handshake.
//   Writes pattern(addr) to every address, reads the whole array back and
//   compares each word, then reports pass/fail, the mismatch count and the
//   first failing address. A per-phase watchdog aborts a stuck handshake.
//
// Ports
//   clk              in   system clock
//   n_reset          in   synchronous reset, active low (shared with the driver)
//   go               in   start a run; sampled only in IDLE or FINISH
//   ready            in   driver idle/complete flag
//   data_out         in   driver read data, valid when ready rises after a read
//   re               out  1 = read, 0 = write
//   start            out  one-cycle request pulse to the driver
//   address          out  address of the current access
//   data_in          out  write data = pattern(address) during the write phase
//   busy             out  run in progress
//   done             out  run finished (FINISH state)
//   pass             out  valid with done: no mismatches and no timeout
//   timeout          out  a handshake phase exceeded TIMEOUT cycles
//   error_count      out  mismatch count, saturating
//   first_fail_addr  out  address of the first mismatch, 0 if none
module sram_pattern_writer #(
  parameter int              ADDR_WIDTH = 13,
  parameter int              DATA_WIDTH = 8,
  parameter logic [7:0]      SEED       = 8'hA5,
  parameter int              TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  go,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  re,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ISSUE, S_WR_WAIT_ACK, S_WR_WAIT_DONE,
    S_RD_ISSUE, S_RD_WAIT_ACK, S_RD_WAIT_DONE, S_FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  // Watchdog counts cycles already spent in the current phase; the abort
  // fires on the TIMEOUT-th cycle that still has no progress.
  localparam int                    CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

  // Pattern is defined over a 13-bit address; narrower addresses are
  // zero-extended, wider ones only contribute their low 13 bits.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [12:0] a13;
    logic [7:0]  p;
    a13 = 13'(a);
    p   = a13[7:0] ^ SEED ^ {3'b000, a13[12:8]};
    return DATA_WIDTH'(p);
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_re;
  logic [CNT_W-1:0]      r_wdog;
  logic                  r_timeout;
  logic [ADDR_WIDTH:0]   r_err;
  logic [ADDR_WIDTH-1:0] r_first;

  logic w_go_ok;
  logic w_hs;
  logic w_expired;
  logic w_last;
  logic w_abort;
  logic w_mismatch;

  assign w_go_ok    = go && (r_state == S_IDLE || r_state == S_FINISH);
  assign w_hs       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign w_expired  = (r_wdog == CNT_LAST);
  assign w_last     = (r_addr == LAST_ADDR);
  assign w_mismatch = (data_out != pattern(r_addr));

  // State register
  always_ff @(posedge clk) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: progress on the awaited ready level wins over expiry
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    unique case (r_state)
      S_IDLE, S_FINISH: if (go) w_next = S_WR_ISSUE;
      S_WR_ISSUE:       if (ready)  w_next = S_WR_WAIT_ACK;
                        else if (w_expired) w_abort = 1'b1;
      S_WR_WAIT_ACK:    if (!ready) w_next = S_WR_WAIT_DONE;
                        else if (w_expired) w_abort = 1'b1;
      S_WR_WAIT_DONE:   if (ready)  w_next = w_last ? S_RD_ISSUE : S_WR_ISSUE;
                        else if (w_expired) w_abort = 1'b1;
      S_RD_ISSUE:       if (ready)  w_next = S_RD_WAIT_ACK;
                        else if (w_expired) w_abort = 1'b1;
      S_RD_WAIT_ACK:    if (!ready) w_next = S_RD_WAIT_DONE;
                        else if (w_expired) w_abort = 1'b1;
      S_RD_WAIT_DONE:   if (ready)  w_next = w_last ? S_FINISH : S_RD_ISSUE;
                        else if (w_expired) w_abort = 1'b1;
      default:          w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_FINISH;
  end

  // Outputs derived from state; start is only raised once ready is seen high
  always_comb begin
    start   = 1'b0;
    busy    = w_hs;
    done    = (r_state == S_FINISH);
    pass    = 1'b0;
    data_in = '0;
    if ((r_state == S_WR_ISSUE || r_state == S_RD_ISSUE) && ready) start = 1'b1;
    if (r_state == S_FINISH) pass = (r_err == '0) && !r_timeout;
    if (r_state == S_WR_ISSUE || r_state == S_WR_WAIT_ACK || r_state == S_WR_WAIT_DONE)
      data_in = pattern(r_addr);
  end

  // Address sequencing, watchdog and result registers
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_addr    <= '0;
      r_re      <= 1'b0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
      r_err     <= '0;
      r_first   <= '0;
    end else begin
      if (w_next != r_state) r_wdog <= '0;
      else if (w_hs)         r_wdog <= r_wdog + CNT_W'(1);

      if (w_go_ok) begin
        r_addr    <= '0;
        r_re      <= 1'b0;
        r_timeout <= 1'b0;
        r_err     <= '0;
        r_first   <= '0;
      end

      if (w_abort) r_timeout <= 1'b1;

      if (r_state == S_WR_WAIT_DONE && ready) begin
        if (w_last) begin
          r_addr <= '0;
          r_re   <= 1'b1;
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end

      if (r_state == S_RD_WAIT_DONE && ready) begin
        if (w_mismatch) begin
          if (r_err == '0) r_first <= r_addr;
          if (r_err != '1) r_err   <= r_err + (ADDR_WIDTH+1)'(1);
        end
        if (!w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign re              = r_re;
  assign address         = r_addr;
  assign timeout         = r_timeout;
  assign error_count     = r_err;
  assign first_fail_addr = r_first;

endmodule

// File: tb/tb_sram_pattern_writer.sv
// Bench for sram_pattern_writer with ADDR_WIDTH=4, TIMEOUT=20.
// A behavioural SRAM driver answers requests; a reference model tracks the
// expected access sequence, completion timing and final status.
module tb_sram_pattern_writer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          go;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          re, start, busy, done, pass, timeout;
  logic [AW-1:0] address, first_fail_addr;
  logic [DW-1:0] data_in;
  logic [AW:0]   error_count;

  sram_pattern_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .n_reset(n_reset), .go(go), .ready(ready), .data_out(data_out),
    .re(re), .start(start), .address(address), .data_in(data_in),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // driver configuration
  logic [DW-1:0] mask [DEPTH];
  bit            rand_mode = 0;
  bit            stuck_en  = 0;
  int            stuck_addr = 0;

  function automatic logic [7:0] pat(input int a);
    return 8'(a & 255) ^ 8'hA5 ^ 8'((a >> 8) & 31);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural SRAM driver: ready drops after a start, stays low a few cycles
  initial begin : driver
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_val;
    logic s_start, s_re, s_rst;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    int low, ack_dly;
    bit pending;
    low = 0; ack_dly = 0; pending = 0; rd_val = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ready = 1'b1;
    data_out = '0;
    forever begin
      @(negedge clk);
      s_start = start; s_re = re; s_addr = address; s_din = data_in; s_rst = n_reset;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        low = 0; ack_dly = 0; pending = 0; ready = 1'b1; data_out = '0;
      end else if (pending) begin
        if (ack_dly > 0) ack_dly--;
        else begin ready = 1'b0; pending = 0; end
      end else if (low > 0) begin
        low--;
        if (low == 0) begin ready = 1'b1; data_out = rd_val; end
      end else if (s_start) begin
        if (!(stuck_en && !s_re && int'(s_addr) == stuck_addr)) begin
          if (!s_re) mem[s_addr] = s_din;
          else       rd_val = mem[s_addr] ^ mask[s_addr];
          low     = rand_mode ? int'($urandom_range(1, 3)) : 2;
          ack_dly = rand_mode ? int'($urandom_range(0, 2)) : 0;
          if (ack_dly == 0) ready = 1'b0;
          else begin pending = 1; ack_dly--; end
        end
      end
    end
  end

  // Reference model and per-cycle compare
  initial begin : model
    bit m_busy, m_done, m_timeout, m_post_rst, m_expect_start, nx_expect_start;
    bit prev_start, m_cur_re;
    int m_err, m_first, k, phase, wcnt, m_addr_cur;
    m_busy = 0; m_done = 0; m_timeout = 0; m_post_rst = 0; m_expect_start = 0;
    prev_start = 0; m_cur_re = 0;
    m_err = 0; m_first = 0; k = 0; phase = 0; wcnt = 0; m_addr_cur = 0;
    forever begin
      @(negedge clk);
      if (m_post_rst) begin
        chk("rst_start", start, 0);
        chk("rst_re", re, 0);
        chk("rst_address", address, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_first_fail", first_fail_addr, 0);
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("start", start, m_expect_start);
      if (prev_start && start) chk("start_consecutive", 1, 0);
      if (m_done) begin
        chk("pass", pass, (m_err == 0 && !m_timeout));
        chk("error_count", error_count, m_err);
        chk("first_fail_addr", first_fail_addr, m_first);
        chk("timeout", timeout, m_timeout);
        if (m_timeout) chk("stuck_address", address, m_addr_cur);
      end
      if (start && m_busy) begin
        m_addr_cur = k % DEPTH;
        m_cur_re   = (k >= DEPTH);
        chk("access_address", address, m_addr_cur);
        chk("access_re", re, m_cur_re);
        if (!m_cur_re) begin
          chk("write_data", data_in, pat(m_addr_cur));
          if (m_addr_cur == 3) chk("write_data_addr3", data_in, 8'hA6);
        end
        k++;
      end
      prev_start = start;

      nx_expect_start = 0;
      m_post_rst = 0;
      if (!n_reset) begin
        m_busy = 0; m_done = 0; m_timeout = 0; m_err = 0; m_first = 0;
        k = 0; phase = 0; wcnt = 0; m_post_rst = 1;
      end else if (!m_busy) begin
        if (go) begin
          m_busy = 1; m_done = 0; m_timeout = 0; m_err = 0; m_first = 0;
          k = 0; phase = 0; nx_expect_start = 1;
        end
      end else if (start) begin
        phase = 1; wcnt = 0;
      end else if (phase == 1) begin
        if (!ready) begin phase = 2; wcnt = 0; end
        else wcnt++;
      end else if (phase == 2) begin
        if (ready) begin
          if (m_cur_re && mask[m_addr_cur] != 0) begin
            if (m_err == 0) m_first = m_addr_cur;
            if (m_err < (2 * DEPTH - 1)) m_err++;
          end
          phase = 0;
          if (k == 2 * DEPTH) begin m_busy = 0; m_done = 1; end
          else nx_expect_start = 1;
        end else wcnt++;
      end
      if (m_busy && phase != 0 && wcnt == TO) begin
        m_busy = 0; m_done = 1; m_timeout = 1; phase = 0;
      end
      m_expect_start = nx_expect_start;
    end
  end

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk({nm, "_done_wait"}, 0, 1);
  endtask

  task automatic set_mask_all(input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++) mask[i] = v;
  endtask

  initial begin : stim
    bit seen;
    set_mask_all('0);
    n_reset = 1'b0;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_address", address, 0);

    // clean run from IDLE
    pulse_go();
    wait_done("clean");
    chk("clean_pass", pass, 1);
    chk("clean_err", error_count, 0);

    // single corrupted read at addr 9, restarted from FINISH
    mask[9] = 8'h01;
    pulse_go();
    wait_done("addr9");
    chk("addr9_pass", pass, 0);
    chk("addr9_err", error_count, 1);
    chk("addr9_first", first_fail_addr, 9);

    // every read corrupted
    set_mask_all(8'h01);
    pulse_go();
    wait_done("all");
    chk("all_err", error_count, 16);
    chk("all_first", first_fail_addr, 0);
    set_mask_all('0);

    // driver never acknowledges the write to addr 5
    stuck_en = 1; stuck_addr = 5;
    pulse_go();
    wait_done("stuck");
    chk("stuck_timeout", timeout, 1);
    chk("stuck_pass", pass, 0);
    chk("stuck_addr", address, 5);
    stuck_en = 0;

    // reset during the read of addr 7
    pulse_go();
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (start && re && address == 4'd7) begin seen = 1; break; end
    end
    if (!seen) chk("rd7_wait", 0, 1);
    @(posedge clk); #1 n_reset = 1'b0;
    @(posedge clk); #1 n_reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_re", re, 0);
    pulse_go();
    wait_done("after_rst");
    chk("after_rst_pass", pass, 1);

    // go pulses while busy must not disturb the run
    pulse_go();
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(2, 8)) @(posedge clk);
      #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
    end
    wait_done("go_busy");
    chk("go_busy_pass", pass, 1);

    // randomized driver timing and corruption
    rand_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++)
        mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      pulse_go();
      for (int p = 0; p < 2; p++) begin
        repeat ($urandom_range(2, 10)) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
      end
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
